// File: rtl/float_mul_requester.sv
// float_mul_requester
// Initiator side of the float multiplier's 4-phase req/ack handshake.
// Takes one operand pair from a valid/ready input stream, holds it on
// mul_a/mul_b while raising mul_req, captures mul_out on ack, waits for
// ack to return low, then offers the product on a valid/ready output stream.
// If ack does not arrive within timeout_cycles REQ cycles, the request is
// abandoned and a zero result is emitted with out_timeout set.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      operand stream handshake
//   in_a, in_b             operands
//   mul_req/mul_ack        4-phase handshake to the multiplier
//   mul_a, mul_b           operands held for the multiplier
//   mul_out                multiplier product (valid while mul_ack=1)
//   out_valid/out_ready    result stream handshake
//   out_data               captured product (0 on timeout)
//   out_timeout            result was produced by a timeout abort
module float_mul_requester #(
  parameter int float_width    = 32,
  parameter int timeout_cycles = 35,
  parameter int cnt_width      = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [float_width-1:0] in_a,
  input  logic [float_width-1:0] in_b,
  output logic                   mul_req,
  input  logic                   mul_ack,
  output logic [float_width-1:0] mul_a,
  output logic [float_width-1:0] mul_b,
  input  logic [float_width-1:0] mul_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [float_width-1:0] out_data,
  output logic                   out_timeout
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_LOW, RESULT} state_t;

  // Counter value on the last REQ cycle that may still wait for ack.
  localparam logic [cnt_width-1:0] TO_LAST = cnt_width'(timeout_cycles - 1);
  localparam logic [cnt_width-1:0] CNT_MAX = '1;

  state_t               state;
  logic [cnt_width-1:0] counter;

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mul_req     <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_timeout <= 1'b0;
      counter     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mul_a   <= in_a;
            mul_b   <= in_b;
            mul_req <= 1'b1;
            counter <= '0;
            state   <= REQ;
          end
        end
        REQ: begin
          // Ack is checked first so it wins over a coincident timeout.
          if (mul_ack) begin
            out_data    <= mul_out;
            out_timeout <= 1'b0;
            mul_req     <= 1'b0;
            state       <= WAIT_LOW;
          end else if (counter == TO_LAST) begin
            // No ack phase happened, so there is no return-to-zero to wait for.
            out_data    <= '0;
            out_timeout <= 1'b1;
            mul_req     <= 1'b0;
            out_valid   <= 1'b1;
            state       <= RESULT;
          end else if (counter != CNT_MAX) begin
            counter <= counter + 1'b1;
          end
        end
        WAIT_LOW: begin
          // A stuck-high ack is a multiplier fault; no timeout here.
          if (!mul_ack) begin
            out_valid <= 1'b1;
            state     <= RESULT;
          end
        end
        RESULT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_mul_requester.sv
module tb_float_mul_requester;
  localparam int TO = 35;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_a = '0, in_b = '0;
  logic        mul_req, mul_ack;
  logic [31:0] mul_a, mul_b, mul_out;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_timeout;

  int checks = 0;
  int failures = 0;

  float_mul_requester #(.float_width(32), .timeout_cycles(TO), .cnt_width(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_req(mul_req), .mul_ack(mul_ack),
    .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_timeout(out_timeout)
  );

  always #5 clk = ~clk;

  // Mock multiplier: ack is seen by the requester K cycles after req rises
  // (K=1 means combinational ack), and drops one cycle after req drops.
  int          ack_k = 1000;
  logic [31:0] mock_val = '0;
  int          rcnt = 0;
  logic        ack_hold = 1'b0;
  always @(posedge clk) begin
    rcnt     <= mul_req ? rcnt + 1 : 0;
    ack_hold <= mul_req && mul_ack;
  end
  assign mul_ack = ack_hold || (mul_req && (rcnt >= ack_k - 1));
  assign mul_out = mul_ack ? mock_val : 32'hDEADBEEF;

  // Drives one complete transaction and reports what was observed.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input int k,
                         input logic [31:0] val, input int hold,
                         output int req_cyc, output int vwait, output logic [31:0] data,
                         output logic to, output bit ack_at_drop, output bit ops_ok,
                         output bit stable, output bit idle_after);
    int n;
    ack_k = k; mock_val = val;
    in_a = a; in_b = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    ops_ok = (mul_a === a) && (mul_b === b) && !in_ready;
    req_cyc = 0; n = 0;
    while (mul_req === 1'b1 && n < 500) begin
      req_cyc++; n++;
      @(negedge clk);
    end
    ack_at_drop = (mul_ack === 1'b1);
    vwait = 0;
    while (out_valid !== 1'b1 && vwait < 50) begin
      vwait++;
      @(negedge clk);
    end
    data = out_data; to = out_timeout;
    stable = (out_valid === 1'b1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== data || out_timeout !== to || in_ready !== 1'b0)
        stable = 0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    idle_after = (in_ready === 1'b1) && (out_valid === 1'b0);
  endtask

  int req_cyc, vwait;
  logic [31:0] data;
  logic to;
  bit ack_at_drop, ops_ok, stable, idle_after;

  task automatic test_reset();
    int n;
    ack_k = 2; mock_val = 32'h12345678;
    in_a = 32'h11111111; in_b = 32'h22222222; in_valid = 1'b1; rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (mul_req !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 || out_timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: req=%b ov=%b ir=%b od=%h ot=%b, want 0 0 1 0 0", mul_req, out_valid, in_ready, out_data, out_timeout);
    end
    rst = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (mul_req !== 1'b1 || mul_a !== 32'h11111111 || mul_b !== 32'h22222222) begin
      failures++;
      $display("FAIL reset_release_accept: req=%b a=%h b=%h, want 1 11111111 22222222", mul_req, mul_a, mul_b);
    end
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin n++; @(negedge clk); end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h12345678) begin
      failures++;
      $display("FAIL reset_first_txn: ov=%b data=%h, want 1 12345678", out_valid, out_data);
    end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_basic();
    run_txn(32'h3F800000, 32'h40000000, 3, 32'h40000000, 0,
            req_cyc, vwait, data, to, ack_at_drop, ops_ok, stable, idle_after);
    checks++;
    if (req_cyc != 3) begin failures++; $display("FAIL basic_req_cycles: got %0d want 3", req_cyc); end
    checks++;
    if (!ack_at_drop) begin failures++; $display("FAIL basic_req_low_before_ack: ack=0 at req drop, want 1"); end
    checks++;
    if (data !== 32'h40000000 || to !== 1'b0) begin
      failures++; $display("FAIL basic_result: data=%h to=%b want 40000000 0", data, to);
    end
    checks++;
    if (vwait != 2) begin failures++; $display("FAIL basic_latency: out_valid wait %0d want 2", vwait); end
    checks++;
    if (!ops_ok) begin failures++; $display("FAIL basic_operands: a=%h b=%h", mul_a, mul_b); end
  endtask

  task automatic test_backpressure();
    run_txn(32'hC4FA0000, 32'h40133333, 2, 32'hC58FC000, 4,
            req_cyc, vwait, data, to, ack_at_drop, ops_ok, stable, idle_after);
    checks++;
    if (data !== 32'hC58FC000 || to !== 1'b0) begin
      failures++; $display("FAIL bp_result: data=%h to=%b want c58fc000 0", data, to);
    end
    checks++;
    if (!stable) begin failures++; $display("FAIL bp_stable: result changed under backpressure, want stable"); end
    checks++;
    if (!idle_after) begin failures++; $display("FAIL bp_idle_after: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
  endtask

  task automatic test_timeout();
    run_txn(32'h40400000, 32'h40800000, 1000, 32'h41400000, 1,
            req_cyc, vwait, data, to, ack_at_drop, ops_ok, stable, idle_after);
    checks++;
    if (req_cyc != TO) begin failures++; $display("FAIL to_req_cycles: got %0d want %0d", req_cyc, TO); end
    checks++;
    if (data !== 32'h0 || to !== 1'b1 || vwait != 0) begin
      failures++; $display("FAIL to_result: data=%h to=%b vwait=%0d want 0 1 0", data, to, vwait);
    end
    run_txn(32'h40400000, 32'h40800000, 4, 32'h41400000, 0,
            req_cyc, vwait, data, to, ack_at_drop, ops_ok, stable, idle_after);
    checks++;
    if (data !== 32'h41400000 || to !== 1'b0 || req_cyc != 4) begin
      failures++; $display("FAIL to_recover: data=%h to=%b req=%0d want 41400000 0 4", data, to, req_cyc);
    end
  endtask

  task automatic test_coincide();
    run_txn(32'h3FC00000, 32'h3FC00000, TO, 32'h40100000, 0,
            req_cyc, vwait, data, to, ack_at_drop, ops_ok, stable, idle_after);
    checks++;
    if (data !== 32'h40100000 || to !== 1'b0 || req_cyc != TO) begin
      failures++; $display("FAIL coincide_ack_wins: data=%h to=%b req=%0d want 40100000 0 %0d", data, to, req_cyc, TO);
    end
    run_txn(32'h3FC00000, 32'h3FC00000, TO + 1, 32'h40100000, 0,
            req_cyc, vwait, data, to, ack_at_drop, ops_ok, stable, idle_after);
    checks++;
    if (data !== 32'h0 || to !== 1'b1 || req_cyc != TO) begin
      failures++; $display("FAIL late_ack_timeout: data=%h to=%b req=%0d want 0 1 %0d", data, to, req_cyc, TO);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_valid;
    ack_k = 10; mock_val = 32'h7F800000;
    in_a = 32'h40A00000; in_b = 32'h40C00000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (mul_req !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL midreset_req: req=%b ir=%b want 0 1", mul_req, in_ready);
    end
    saw_valid = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || mul_req !== 1'b0) saw_valid = 1;
    end
    checks++;
    if (saw_valid) begin failures++; $display("FAIL midreset_no_result: activity seen after reset, want none"); end
    run_txn(32'h00000000, 32'h3F800000, 2, 32'h00000000, 0,
            req_cyc, vwait, data, to, ack_at_drop, ops_ok, stable, idle_after);
    checks++;
    if (data !== 32'h0 || to !== 1'b0 || req_cyc != 2) begin
      failures++; $display("FAIL midreset_next: data=%h to=%b req=%0d want 0 0 2", data, to, req_cyc);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, v, exp_data;
    int k, hold, exp_req;
    bit exp_to;
    for (int i = 0; i < 20; i++) begin
      a = $urandom; b = $urandom; v = $urandom;
      k = $urandom_range(1, TO + 5); hold = $urandom_range(0, 3);
      // Reference: the product passes through if ack arrives within TO cycles.
      exp_to   = (k > TO);
      exp_data = exp_to ? 32'h0 : v;
      exp_req  = exp_to ? TO : k;
      run_txn(a, b, k, v, hold, req_cyc, vwait, data, to, ack_at_drop, ops_ok, stable, idle_after);
      checks++;
      if (data !== exp_data || to !== exp_to || req_cyc != exp_req || !ops_ok || !stable || !idle_after ||
          vwait != (exp_to ? 0 : 2)) begin
        failures++;
        $display("FAIL random_%0d: k=%0d data=%h to=%b req=%0d vw=%0d ops=%b st=%b idle=%b want data=%h to=%b req=%0d",
                 i, k, data, to, req_cyc, vwait, ops_ok, stable, idle_after, exp_data, exp_to, exp_req);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_coincide();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/float_mul_requester.md
Name: float_mul_requester

Overview:
- Hardware initiator for the float multiplier's 4-phase req/ack interface.
- Accepts operand pairs on a valid/ready stream and drives req/a/b to the multiplier.
- Waits for ack, captures the product, then completes the return-to-zero phase.
- Presents each product on a valid/ready result stream, with a timeout flag if ack never arrives.
- Sits between an operand-issue stage (e.g. dot-product sequencer) and one multiplier instance.

Parameters:
- float_width, 32, width of operands and result (IEEE single by default).
- timeout_cycles, 35, maximum cycles in REQ without ack before abort; must be >= 2.
- cnt_width, 6, width of the timeout counter; must satisfy 2^cnt_width > timeout_cycles.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand pair available.
- in_ready  output  1  requester can accept an operand pair.
- in_a  input  float_width  operand a.
- in_b  input  float_width  operand b.
- mul_req  output  1  request to multiplier.
- mul_ack  input  1  multiplier acknowledge.
- mul_a  output  float_width  operand a to multiplier.
- mul_b  output  float_width  operand b to multiplier.
- mul_out  input  float_width  multiplier product; valid while mul_ack=1.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_data  output  float_width  captured product (0 on timeout).
- out_timeout  output  1  result was aborted by timeout.

Behaviour:
- Reset, synchronous and active-high, sampled on the rising edge of clk:
  - Outputs: state=IDLE, mul_req=0, mul_a=0, mul_b=0, out_valid=0, out_data=0, out_timeout=0, counter=0.
  - Reset mid-transaction abandons it immediately.
  - mul_req drops the cycle after the reset edge; no result is emitted.
- in_ready = (state==IDLE); combinational from state only.
- States: IDLE, REQ, WAIT_LOW, RESULT.
- IDLE:
  - in_valid=1 at an edge: latch in_a/in_b into mul_a/mul_b, set mul_req=1, clear counter, go REQ.
  - mul_a/mul_b are held stable until the next accept.
- REQ:
  - mul_req=1. Counter increments each cycle, saturating.
  - mul_ack=1 sampled: out_data<=mul_out, out_timeout<=0, mul_req<=0, go WAIT_LOW.
  - Ack is sampled starting on the first REQ cycle, so a combinational or 1-cycle ack is legal.
  - Counter reaches timeout_cycles-1 with mul_ack=0: out_data<=0, out_timeout<=1, mul_req<=0, go RESULT (skip WAIT_LOW).
  - Ack wins if ack and timeout coincide.
- WAIT_LOW:
  - mul_req=0; stay while mul_ack=1.
  - mul_ack=0 sampled: out_valid<=1, go RESULT.
  - No timeout in this state; a stuck-high ack is a multiplier fault.
- RESULT:
  - out_valid=1; out_data and out_timeout held stable.
  - out_valid && out_ready at an edge: out_valid<=0, go IDLE.
  - No back-to-back accept in the same cycle; in_ready is low in RESULT.
- Latency, in_valid accepted at edge E with the multiplier acking K cycles after req rises:
  - mul_req high from E to E+K.
  - out_valid high by E+K+2, given ack drops one cycle after req.
- Throughput: one transaction in flight; no pipelining across the handshake.
- Sign, zero and special values pass through unmodified; the block does no arithmetic.

Test Plan:
- Reset 2 cycles with a pair pending -> mul_req=0, out_valid=0, in_ready=1; after release, pair accepted next edge.
- in_a=0x3F800000 (1.0), in_b=0x40000000 (2.0); mock multiplier acks 3 cycles after req with 0x40000000 -> mul_req high exactly 3 cycles; mul_req low before ack drops; out_data=0x40000000, out_timeout=0.
- in_a=0xC4FA0000 (-2000.0), in_b=0x40133333 (2.3); mock returns 0xC58FC000 (-4600.0); out_ready held low 4 cycles -> out_valid and out_data stable 4 cycles, then IDLE one edge after out_ready=1.
- Mock never acks -> mul_req deasserts after 35 cycles; out_valid=1, out_timeout=1, out_data=0; next pair completes normally.
- Ack and timeout on the same cycle (ack at cycle 34) -> captured product, out_timeout=0.
- rst pulsed while in REQ with ack pending -> mul_req=0 after the reset edge, no out_valid; the subsequent 0.0*1.0 transaction returns 0x00000000 with out_timeout=0.
